mul_seq: RTL and testbench
==========================

MUL_SEQ -- requirements
Module: mul_seq

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the operand width in bits; legal range 2..32.
REQ-002 Parameter STEP, default 1, SHALL set the multiplier bits retired per compute cycle; WIDTH SHALL be an integer multiple of STEP.
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 start  input  1  SHALL request a new multiplication, sampled on the rising edge of clk.
REQ-006 a  input  WIDTH  SHALL carry the multiplicand, sampled with start.
REQ-007 b  input  WIDTH  SHALL carry the multiplier, sampled with start.
REQ-008 signed_i  input  1  SHALL select the number format, sampled with start: 1 = two's complement, 0 = unsigned.
REQ-009 result  output  2*WIDTH  SHALL carry the registered product of the last completed operation.
REQ-010 busy  output  1  SHALL be high while an operation is in progress.
REQ-011 done  output  1  SHALL be a one-cycle pulse marking the cycle in which result is updated.

Function
REQ-012 Let N = WIDTH/STEP; the FSM SHALL have three states: IDLE, CALC and FIX.
REQ-013 In IDLE with start=1 at edge k, the block SHALL latch a, b and signed_i, enter CALC and set busy=1 from edge k.
REQ-014 In signed mode, the block SHALL latch the operand magnitudes and record the product sign as the XOR of the operand MSBs.
REQ-015 CALC SHALL last exactly N cycles, each adding (multiplier STEP-bit slice × multiplicand shifted) into an internal 2*WIDTH accumulator, LSB slice first.
REQ-016 After N CALC cycles, the FSM SHALL enter FIX for one cycle, applying two's-complement negation to the accumulator when the recorded sign is 1.
REQ-017 At edge k+N+1, the FSM SHALL write result, drop busy to 0, pulse done=1 for one cycle, and return to IDLE.
REQ-018 Total latency from the start edge to the result edge SHALL be N+1 cycles; busy SHALL be high for exactly N+1 cycles.
REQ-019 result SHALL hold its previous value for the whole of CALC and FIX and change only at the done edge.
REQ-020 start asserted while busy=1 SHALL be ignored, with no effect on operands or timing.
REQ-021 start asserted in the done cycle (busy=0) SHALL be accepted, giving back-to-back operations with no idle gap.
REQ-022 The product SHALL be exact in 2*WIDTH bits for all operands, including the most-negative × most-negative case in signed mode; no overflow flag is provided.
REQ-023 A zero operand SHALL still take the full N+1 cycles, with no early termination.
REQ-024 Changes on a, b or signed_i after the start edge SHALL NOT affect the operation in flight.

Reset
REQ-025 While rst=1, the block SHALL force result=0, busy=0 and done=0, clear the state to IDLE, and clear the counter, accumulator and latched operands.
REQ-026 rst asserted mid-operation SHALL abort it immediately, with no done pulse and no result update.
REQ-027 After rst deasserts, the block SHALL accept start on the first rising edge.

Verification (WIDTH=8, STEP=1, N=8 unless stated)
REQ-028 Unsigned: a=255, b=255, signed_i=0, start for 1 cycle -> busy high for 9 cycles, then done pulse and result=65025 (0xFE01).
REQ-029 Signed extremes: a=0x80, b=0x80 -> result=16384 (0x4000); a=0x80, b=0x01 -> result=0xFF80; a=0xFF, b=0x02 -> result=0xFFFE.
REQ-030 Busy and back-to-back: re-assert start at cycle 3 of CALC with a=9 -> ignored, result=3*5=15; then start in the done cycle with a=7, b=6 -> busy stays 0 for only that cycle, result=42 after 9 more cycles.
REQ-031 Mid-operation reset: start 12×12, assert rst at cycle 4 -> busy, done and result all 0 immediately, with no done pulse; a new start of 12×12 after reset -> 144.
REQ-032 Parameter sweep: WIDTH=16, STEP=4 (N=4), a=0xFFFF, b=0xFFFF unsigned -> 5-cycle busy, result=0xFFFE0001; random signed/unsigned pairs checked against a reference model for WIDTH ∈ {4, 8, 16}.
REQ-033 Hold: result is unchanged across a full operation until the done edge, and stays stable through at least 10 idle cycles afterwards.

Source files
------------

// File: rtl/mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : mul_seq
// Brief    : Sequential shift-and-add multiplier, STEP multiplier bits per
//            cycle, unsigned or two's-complement operands, N+1 cycle latency.
// Revision : 1.0
// ============================================================================
module mul_seq #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_i,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy,
    output logic                 done
);

    localparam int N  = WIDTH / STEP;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t             state_q,  state_d;
    logic [CW-1:0]      cnt_q,    cnt_d;
    logic [PW-1:0]      acc_q,    acc_d;
    logic [PW-1:0]      mcand_q,  mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic               neg_q,    neg_d;
    logic [PW-1:0]      result_q, result_d;
    logic               done_q,   done_d;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [PW-1:0]      partial;

    // Magnitudes fit in WIDTH unsigned bits, even for the most-negative value.
    assign a_mag   = (signed_i && a[WIDTH-1]) ? -a : a;
    assign b_mag   = (signed_i && b[WIDTH-1]) ? -b : b;
    assign partial = mcand_q * PW'(mplier_q[STEP-1:0]);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        result_d = result_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = PW'(a_mag);
                    mplier_d = b_mag;
                    acc_d    = '0;
                    cnt_d    = '0;
                    neg_d    = signed_i & (a[WIDTH-1] ^ b[WIDTH-1]);
                    state_d  = CALC;
                end
            end
            CALC: begin
                acc_d    = acc_q + partial;
                mcand_d  = mcand_q << STEP;
                mplier_d = mplier_q >> STEP;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    cnt_d   = '0;
                    state_d = FIX;
                end
            end
            FIX: begin
                result_d = neg_q ? -acc_q : acc_q;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign result = result_q;
    assign busy   = (state_q != IDLE);
    assign done   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_seq
// Brief    : Directed and randomized self-checking bench for mul_seq at
//            WIDTH/STEP = 8/1, 16/4 and 4/2.
// Revision : 1.0
// ============================================================================
module tb_mul_seq;

    logic        clk;
    logic        rst;

    logic        st8,  s8;
    logic [7:0]  a8,   b8;
    logic [15:0] res8;
    logic        busy8, done8;

    logic        st16, s16;
    logic [15:0] a16,  b16;
    logic [31:0] res16;
    logic        busy16, done16;

    logic        st4,  s4;
    logic [3:0]  a4,   b4;
    logic [7:0]  res4;
    logic        busy4, done4;

    int n_cmp  = 0;
    int n_fail = 0;

    mul_seq #(.WIDTH(8), .STEP(1)) u_dut8 (
        .clk(clk), .rst(rst), .start(st8), .a(a8), .b(b8), .signed_i(s8),
        .result(res8), .busy(busy8), .done(done8)
    );

    mul_seq #(.WIDTH(16), .STEP(4)) u_dut16 (
        .clk(clk), .rst(rst), .start(st16), .a(a16), .b(b16), .signed_i(s16),
        .result(res16), .busy(busy16), .done(done16)
    );

    mul_seq #(.WIDTH(4), .STEP(2)) u_dut4 (
        .clk(clk), .rst(rst), .start(st4), .a(a4), .b(b4), .signed_i(s4),
        .result(res4), .busy(busy4), .done(done4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic [15:0] av, input logic [15:0] bv,
                         input logic sv, input logic st);
        case (sel)
            0:       begin a8  = av[7:0]; b8  = bv[7:0]; s8  = sv; st8  = st; end
            1:       begin a16 = av;      b16 = bv;      s16 = sv; st16 = st; end
            default: begin a4  = av[3:0]; b4  = bv[3:0]; s4  = sv; st4  = st; end
        endcase
    endtask

    function automatic logic [31:0] get_res(input int sel);
        case (sel)
            0:       return {16'd0, res8};
            1:       return res16;
            default: return {24'd0, res4};
        endcase
    endfunction

    function automatic logic get_busy(input int sel);
        case (sel)
            0:       return busy8;
            1:       return busy16;
            default: return busy4;
        endcase
    endfunction

    function automatic logic get_done(input int sel);
        case (sel)
            0:       return done8;
            1:       return done16;
            default: return done4;
        endcase
    endfunction

    function automatic int width_of(input int sel);
        case (sel)
            0:       return 8;
            1:       return 16;
            default: return 4;
        endcase
    endfunction

    function automatic int n_of(input int sel);
        case (sel)
            0:       return 8;
            1:       return 4;
            default: return 2;
        endcase
    endfunction

    // Reference product: sign-extend in 64-bit arithmetic, keep 2*w bits.
    function automatic logic [31:0] ref_mul(input int w, input logic [15:0] av,
                                            input logic [15:0] bv, input logic sv);
        longint      x;
        longint      y;
        longint      p;
        logic [63:0] m;
        x = longint'({48'd0, av});
        y = longint'({48'd0, bv});
        if (sv && av[w-1]) x = x - (longint'(1) << w);
        if (sv && bv[w-1]) y = y - (longint'(1) << w);
        p = x * y;
        m = 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
        return m[31:0];
    endfunction

    // Ticks until done is seen (bounded); returns number of edges waited.
    task automatic wait_done(input int sel, output int t);
        t = 0;
        while (t < 40 && !get_done(sel)) begin
            tick();
            t++;
        end
    endtask

    task automatic run_op(input int sel, input logic [15:0] av, input logic [15:0] bv,
                          input logic sv, input logic [31:0] exp, input string tag);
        int          t;
        logic        got;
        logic        busy_ok;
        logic        hold_ok;
        logic [31:0] prev;
        prev    = get_res(sel);
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        got     = 1'b0;
        t       = 0;
        drive(sel, av, bv, sv, 1'b1);
        tick();
        // Scramble inputs: the operation in flight must not see them.
        drive(sel, ~av, ~bv, ~sv, 1'b0);
        check({tag, "_busy_start"}, 32'(get_busy(sel)), 32'd1);
        while (t < 40 && !got) begin
            tick();
            t++;
            if (get_done(sel)) begin
                got = 1'b1;
            end else begin
                if (!get_busy(sel))          busy_ok = 1'b0;
                if (get_res(sel) !== prev)   hold_ok = 1'b0;
            end
        end
        check({tag, "_latency"}, 32'(t), 32'(n_of(sel) + 1));
        check({tag, "_busy_run"}, 32'(busy_ok), 32'd1);
        check({tag, "_hold"}, 32'(hold_ok), 32'd1);
        check({tag, "_result"}, get_res(sel), exp);
        check({tag, "_busy_done"}, 32'(get_busy(sel)), 32'd0);
        tick();
        check({tag, "_done_pulse"}, 32'(get_done(sel)), 32'd0);
    endtask

    initial begin
        int          t;
        logic        flag;
        logic [15:0] av;
        logic [15:0] bv;
        logic        sv;
        int          sel;
        int          w;

        rst = 1'b1;
        drive(0, 16'd0, 16'd0, 1'b0, 1'b0);
        drive(1, 16'd0, 16'd0, 1'b0, 1'b0);
        drive(2, 16'd0, 16'd0, 1'b0, 1'b0);
        tick();
        tick();
        check("rst_result8", get_res(0), 32'd0);
        check("rst_busy8",   32'(busy8), 32'd0);
        check("rst_done8",   32'(done8), 32'd0);
        check("rst_result16", get_res(1), 32'd0);

        // Start accepted on the first edge after reset release.
        rst = 1'b0;
        run_op(0, 16'd255, 16'd255, 1'b0, 32'h0000FE01, "u255x255");

        run_op(0, 16'h0080, 16'h0080, 1'b1, 32'h00004000, "s80x80");
        run_op(0, 16'h0080, 16'h0001, 1'b1, 32'h0000FF80, "s80x01");
        run_op(0, 16'h00FF, 16'h0002, 1'b1, 32'h0000FFFE, "sFFx02");
        run_op(0, 16'd0,    16'd77,   1'b0, 32'h00000000, "zero");

        // Start during CALC is ignored; start in the done cycle is accepted.
        drive(0, 16'd3, 16'd5, 1'b0, 1'b1);
        tick();
        drive(0, 16'd3, 16'd5, 1'b0, 1'b0);
        tick();
        tick();
        drive(0, 16'd9, 16'd5, 1'b0, 1'b1);
        tick();
        drive(0, 16'd1, 16'd1, 1'b1, 1'b0);
        wait_done(0, t);
        check("ign_latency", 32'(t), 32'd6);
        check("ign_result",  get_res(0), 32'd15);
        check("ign_busy",    32'(busy8), 32'd0);
        drive(0, 16'd7, 16'd6, 1'b0, 1'b1);
        tick();
        drive(0, 16'd0, 16'd0, 1'b0, 1'b0);
        check("b2b_busy", 32'(busy8), 32'd1);
        wait_done(0, t);
        check("b2b_latency", 32'(t), 32'd9);
        check("b2b_result",  get_res(0), 32'd42);

        // Reset mid-operation aborts immediately, with no done pulse.
        tick();
        drive(0, 16'd12, 16'd12, 1'b0, 1'b1);
        tick();
        drive(0, 16'd12, 16'd12, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("mrst_busy",   32'(busy8), 32'd0);
        check("mrst_done",   32'(done8), 32'd0);
        check("mrst_result", get_res(0), 32'd0);
        flag = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done8 || busy8) flag = 1'b1;
        end
        check("mrst_quiet", 32'(flag), 32'd0);
        rst = 1'b0;
        run_op(0, 16'd12, 16'd12, 1'b0, 32'd144, "after_rst");

        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_hold", get_res(0), 32'd144);
        end

        run_op(1, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, "w16_uFFFF");
        run_op(1, 16'h8000, 16'h8000, 1'b1, 32'h40000000, "w16_s8000");
        run_op(2, 16'h0008, 16'h0007, 1'b1, 32'h000000C8, "w4_s8x7");
        run_op(2, 16'h000F, 16'h000F, 1'b0, 32'h000000E1, "w4_uFxF");

        for (int i = 0; i < 18; i++) begin
            sel = i % 3;
            w   = width_of(sel);
            av  = 16'($urandom) & 16'((32'd1 << w) - 32'd1);
            bv  = 16'($urandom) & 16'((32'd1 << w) - 32'd1);
            sv  = 1'($urandom_range(0, 1));
            run_op(sel, av, bv, sv, ref_mul(w, av, bv, sv), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
